// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_ctrl_pkg
//  Brief    : Shared mode encodings and constants for the HH:MM clock controller.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10
    } mode_t;

    localparam logic [5:0] SEC_MAX = 6'd59;

    // Bit positions inside the display blink mask
    localparam int DIG_HR_H  = 3;
    localparam int DIG_HR_L  = 2;
    localparam int DIG_MIN_H = 1;
    localparam int DIG_MIN_L = 0;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Brief    : Synchronises an active-low key, debounces it with a saturating
//             counter and emits one press pulse per hold plus a hold level.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEB_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press,
    output logic o_hold
);

    localparam int c_CNT_W = $clog2(DEB_CYCLES + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_press;
    logic               w_low;

    assign w_low = ~r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (!w_low) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_W'(DEB_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Pulse lands in the cycle the counter saturates
            r_press <= w_low && (r_cnt == c_CNT_W'(DEB_CYCLES - 1));
        end
    end

    assign o_press = r_press;
    assign o_hold  = w_low && (r_cnt == c_CNT_W'(DEB_CYCLES));

endmodule
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_mode_ctrl
//  Brief    : RUN/SET_HR/SET_MIN controller for the HH:MM clock: key handling,
//             seconds counter, counter strobes and digit blink mask.
//             Optional UP auto-repeat enabled by defining AUTO_REPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 1048576,
    parameter int BLINK_HALF  = 12500000,
    parameter int REPEAT_DLY  = 25000000,
    parameter int REPEAT_RATE = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_up_n,
    input  logic       sec_tick,
    output logic       min_inc,
    output logic       min_adj,
    output logic       hr_adj,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic [3:0] blink_mask
);

    localparam int c_BLINK_W = $clog2(BLINK_HALF);

    mode_t                r_state;
    mode_t                w_state_nxt;
    logic [5:0]           r_sec_cnt;
    logic [5:0]           w_sec_nxt;
    logic                 r_min_inc, r_min_adj, r_hr_adj, r_sec_clr;
    logic                 w_min_inc_nxt, w_min_adj_nxt, w_hr_adj_nxt, w_sec_clr_nxt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_ph;
    logic                 w_blink_restart;
    logic [3:0]           w_mask;
    logic                 w_mode_press, w_up_press, w_up_hold, w_mode_hold_unused;
    logic                 w_rep_fire, w_repeating;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_mode_n),
        .o_press (w_mode_press),
        .o_hold  (w_mode_hold_unused)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_up_n),
        .o_press (w_up_press),
        .o_hold  (w_up_hold)
    );

`ifdef AUTO_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    logic               r_rep_arm;
    logic               r_repeating;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic               w_rep_stop;
    logic               w_rep_start;

    assign w_rep_start = w_up_press && !w_mode_press && (r_state != MODE_RUN);
    assign w_rep_stop  = !w_up_hold || w_mode_press || (r_state == MODE_RUN);
    assign w_rep_fire  = r_rep_arm && !w_rep_stop &&
                         (r_repeating ? (r_rep_cnt == c_REP_W'(REPEAT_RATE))
                                      : (r_rep_cnt == c_REP_W'(REPEAT_DLY)));
    assign w_repeating = r_repeating;

    // Counter holds the number of cycles since the press (or the last repeat)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_arm   <= 1'b0;
            r_repeating <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (w_rep_start) begin
            r_rep_arm   <= 1'b1;
            r_repeating <= 1'b0;
            r_rep_cnt   <= c_REP_W'(1);
        end else if (w_rep_stop) begin
            r_rep_arm   <= 1'b0;
            r_repeating <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (r_rep_arm) begin
            if (w_rep_fire) begin
                r_repeating <= 1'b1;
                r_rep_cnt   <= c_REP_W'(1);
            end else begin
                r_rep_cnt   <= r_rep_cnt + 1'b1;
            end
        end
    end
`else
    logic w_repeat_unused;

    assign w_repeat_unused = ^{REPEAT_DLY, REPEAT_RATE, w_up_hold};
    assign w_rep_fire      = 1'b0;
    assign w_repeating     = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_sec_nxt       = r_sec_cnt;
        w_min_inc_nxt   = 1'b0;
        w_min_adj_nxt   = 1'b0;
        w_hr_adj_nxt    = 1'b0;
        w_sec_clr_nxt   = 1'b0;
        w_blink_restart = w_repeating;
        case (r_state)
            MODE_RUN: begin
                if (sec_tick) begin
                    if (r_sec_cnt == SEC_MAX) begin
                        w_sec_nxt     = '0;
                        w_min_inc_nxt = 1'b1;
                    end else begin
                        w_sec_nxt     = r_sec_cnt + 6'd1;
                    end
                end
                if (w_mode_press) begin
                    w_state_nxt     = MODE_SET_HR;
                    w_blink_restart = 1'b1;
                end
            end
            MODE_SET_HR: begin
                if (w_mode_press) begin
                    w_state_nxt     = MODE_SET_MIN;
                    w_blink_restart = 1'b1;
                end else if (w_up_press || w_rep_fire) begin
                    w_hr_adj_nxt    = 1'b1;
                    w_blink_restart = w_blink_restart | w_up_press;
                end
            end
            MODE_SET_MIN: begin
                // Leaving set mode restarts seconds; a coincident tick is dropped
                if (w_mode_press) begin
                    w_state_nxt   = MODE_RUN;
                    w_sec_nxt     = '0;
                    w_sec_clr_nxt = 1'b1;
                end else if (w_up_press || w_rep_fire) begin
                    w_min_adj_nxt   = 1'b1;
                    w_blink_restart = w_blink_restart | w_up_press;
                end
            end
            default: w_state_nxt = MODE_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= MODE_RUN;
            r_sec_cnt   <= '0;
            r_min_inc   <= 1'b0;
            r_min_adj   <= 1'b0;
            r_hr_adj    <= 1'b0;
            r_sec_clr   <= 1'b0;
            r_blink_cnt <= '0;
            r_ph        <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sec_cnt <= w_sec_nxt;
            r_min_inc <= w_min_inc_nxt;
            r_min_adj <= w_min_adj_nxt;
            r_hr_adj  <= w_hr_adj_nxt;
            r_sec_clr <= w_sec_clr_nxt;
            if (w_blink_restart) begin
                r_blink_cnt <= '0;
                r_ph        <= 1'b0;
            end else if (r_blink_cnt == c_BLINK_W'(BLINK_HALF - 1)) begin
                r_blink_cnt <= '0;
                r_ph        <= ~r_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_mask = 4'b0000;
        case (r_state)
            MODE_SET_HR: begin
                w_mask[DIG_HR_H] = r_ph;
                w_mask[DIG_HR_L] = r_ph;
            end
            MODE_SET_MIN: begin
                w_mask[DIG_MIN_H] = r_ph;
                w_mask[DIG_MIN_L] = r_ph;
            end
            default: w_mask = 4'b0000;
        endcase
    end

    assign min_inc    = r_min_inc;
    assign min_adj    = r_min_adj;
    assign hr_adj     = r_hr_adj;
    assign sec_clr    = r_sec_clr;
    assign mode       = r_state;
    assign blink_mask = w_mask;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_mode_ctrl
//  Brief    : Scoreboard bench for clock_mode_ctrl with short timing parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_mode_ctrl;

    localparam int DEB   = 4;
    localparam int BLINK = 8;
    localparam int RDLY  = 16;
    localparam int RRATE = 4;
    localparam int LAT   = DEB + 3;   // key driven -> strobe visible

    localparam int K_MIN_INC = 0;
    localparam int K_MIN_ADJ = 1;
    localparam int K_HR_ADJ  = 2;
    localparam int K_SEC_CLR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_mode_n = 1'b1;
    logic       key_up_n = 1'b1;
    logic       sec_tick = 1'b0;
    logic       min_inc, min_adj, hr_adj, sec_clr;
    logic [1:0] mode;
    logic [3:0] blink_mask;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    clock_mode_ctrl #(
        .DEB_CYCLES  (DEB),
        .BLINK_HALF  (BLINK),
        .REPEAT_DLY  (RDLY),
        .REPEAT_RATE (RRATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_mode_n (key_mode_n),
        .key_up_n   (key_up_n),
        .sec_tick   (sec_tick),
        .min_inc    (min_inc),
        .min_adj    (min_adj),
        .hr_adj     (hr_adj),
        .sec_clr    (sec_clr),
        .mode       (mode),
        .blink_mask (blink_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: every observed strobe must match the head of the scoreboard
    always @(negedge clk) begin
        logic [3:0] s;
        exp_t       e;
        s = {sec_clr, hr_adj, min_adj, min_inc};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL strobe_missing kind=%0d expected at cyc=%0d, not observed", sb[0].kind, sb[0].cyc);
            void'(sb.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            if (s[k]) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL strobe_unexpected got kind=%0d at cyc=%0d, expected no strobe", k, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind !== k || e.cyc !== cyc) begin
                        failures++;
                        $display("FAIL strobe got kind=%0d cyc=%0d expected kind=%0d cyc=%0d", k, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_mode();
        key_mode_n = 1'b0;
        step(LAT);
        key_mode_n = 1'b1;
        step(4);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(3);
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL reset_mode got=%b expected=00", mode);
        end
        checks++;
        if (blink_mask !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mask got=%b expected=0000", blink_mask);
        end
        checks++;
        if ({min_inc, min_adj, hr_adj, sec_clr} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b expected=0000", {min_inc, min_adj, hr_adj, sec_clr});
        end
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_run_wrap();
        for (int i = 1; i <= 60; i++) begin
            sec_tick = 1'b1;
            if (i == 60) sb.push_back('{cyc + 1, K_MIN_INC});
            step(1);
            sec_tick = 1'b0;
            step(1);
        end
        step(5);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL run_wrap_pending got=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_mode_blink();
        int cm, e, exp_mode;
        logic [3:0] exp_mask;
        key_up_n = 1'b0;
        step(3);
        key_up_n = 1'b1;
        step(4);
        cm = cyc;
        e  = cm + LAT;
        key_mode_n = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step(1);
            if (n == 10) key_mode_n = 1'b1;
            exp_mode = (cyc < e) ? 0 : 1;
            exp_mask = (cyc < e) ? 4'b0000 : ((((cyc - e) / BLINK) % 2) == 1 ? 4'b1100 : 4'b0000);
            checks++;
            if (mode !== 2'(exp_mode)) begin
                failures++;
                $display("FAIL blink_mode cyc=%0d got=%b expected=%0d", cyc, mode, exp_mode);
            end
            checks++;
            if (blink_mask !== exp_mask) begin
                failures++;
                $display("FAIL blink_mask_hr cyc=%0d got=%b expected=%b", cyc, blink_mask, exp_mask);
            end
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL mode_blink_pending got=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_set_min();
        int cu;
        press_mode();
        checks++;
        if (mode !== 2'b10) begin
            failures++;
            $display("FAIL set_min_mode got=%b expected=10", mode);
        end
        for (int p = 0; p < 3; p++) begin
            cu = cyc;
            key_up_n = 1'b0;
            sb.push_back('{cu + LAT, K_MIN_ADJ});
            for (int n = 1; n <= 20; n++) begin
                step(1);
                if (n == 8) key_up_n = 1'b1;
                if (cyc >= cu + LAT && cyc < cu + LAT + BLINK) begin
                    checks++;
                    if (blink_mask !== 4'b0000) begin
                        failures++;
                        $display("FAIL press_visible cyc=%0d got=%b expected=0000", cyc, blink_mask);
                    end
                end else if (cyc == cu + LAT + BLINK) begin
                    checks++;
                    if (blink_mask !== 4'b0011) begin
                        failures++;
                        $display("FAIL press_blank cyc=%0d got=%b expected=0011", cyc, blink_mask);
                    end
                end
            end
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL set_min_pending got=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_mode_up_same();
        sb.push_back('{cyc + LAT, K_SEC_CLR});
        press_mode();
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL back_to_run_mode got=%b expected=00", mode);
        end
        // Leave a non-zero seconds count frozen while setting
        for (int i = 0; i < 10; i++) begin
            sec_tick = 1'b1;
            step(1);
            sec_tick = 1'b0;
            step(1);
        end
        press_mode();
        checks++;
        if (mode !== 2'b01) begin
            failures++;
            $display("FAIL enter_hr_mode got=%b expected=01", mode);
        end
        key_mode_n = 1'b0;
        key_up_n   = 1'b0;
        step(LAT);
        checks++;
        if (mode !== 2'b10) begin
            failures++;
            $display("FAIL same_cycle_mode got=%b expected=10", mode);
        end
        key_mode_n = 1'b1;
        key_up_n   = 1'b1;
        step(6);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL same_cycle_pending got=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_exit_tick();
        int cm;
        cm = cyc;
        key_mode_n = 1'b0;
        sb.push_back('{cm + LAT, K_SEC_CLR});
        step(LAT - 1);
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL exit_mode got=%b expected=00", mode);
        end
        key_mode_n = 1'b1;
        step(4);
        // Seconds must restart from zero: the wrap comes on exactly the 60th tick
        for (int i = 1; i <= 60; i++) begin
            sec_tick = 1'b1;
            if (i == 60) sb.push_back('{cyc + 1, K_MIN_INC});
            step(1);
            sec_tick = 1'b0;
            step(1);
        end
        step(4);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL exit_pending got=%0d expected=0", sb.size());
        end
        press_mode();
        key_up_n = 1'b0;
        step(LAT);
        checks++;
        if (hr_adj !== 1'b1) begin
            failures++;
            $display("FAIL inflight_hr_adj got=%b expected=1", hr_adj);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({min_inc, min_adj, hr_adj, sec_clr} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_strobes got=%b expected=0000", {min_inc, min_adj, hr_adj, sec_clr});
        end
        checks++;
        if (mode !== 2'b00 || blink_mask !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mode_mask got=%b/%b expected=00/0000", mode, blink_mask);
        end
        step(2);
        key_up_n = 1'b1;
        rst = 1'b1;
        step(3);
    endtask

    task automatic test_auto_repeat();
        int cu;
        press_mode();
        cu = cyc;
        key_up_n = 1'b0;
        sb.push_back('{cu + LAT, K_HR_ADJ});
`ifdef AUTO_REPEAT_EN
        for (int k = 0; k < 5; k++) sb.push_back('{cu + LAT + RDLY + k * RRATE, K_HR_ADJ});
`endif
        step(40);
        key_up_n = 1'b1;
        step(30);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL repeat_pending got=%0d expected=0", sb.size());
        end
        checks++;
        if (mode !== 2'b01) begin
            failures++;
            $display("FAIL repeat_mode got=%b expected=01", mode);
        end
    endtask

    initial begin
        test_reset();
        test_run_wrap();
        test_mode_blink();
        test_set_min();
        test_mode_up_same();
        test_exit_tick();
        test_auto_repeat();
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
